// File: rtl/pyrm_wb_arbiter_pkg.sv
// Shared widths, grant-source encoding and rd helpers for the writeback arbiter.
// The rd slice width lives here so every file agrees on which address bits matter.
package pyrm_wb_arbiter_pkg;

    localparam int XLEN         = 64;
    localparam int RF_ADDR_BITS = 5;

    typedef enum logic {
        SRC_EXEC = 1'b0,
        SRC_MEM  = 1'b1
    } wb_src_e;

    // Writes to x0 are architecturally discarded, so they never need the port.
    function automatic logic is_x0(input logic [RF_ADDR_BITS-1:0] rd);
        return rd == '0;
    endfunction

endpackage

// File: rtl/pyrm_wb_rr_pick.sv
// Two-way round-robin pick between the execute and load writeback requests.
// Grants are one-hot; the side that did not win last time wins a conflict.
module pyrm_wb_rr_pick (
    input  logic i_req_exec,
    input  logic i_req_mem,
    input  logic i_last_mem,
    output logic o_gnt_exec,
    output logic o_gnt_mem
);

    assign o_gnt_exec = i_req_exec && (!i_req_mem || i_last_mem);
    assign o_gnt_mem  = i_req_mem  && (!i_req_exec || !i_last_mem);

endmodule

// File: rtl/pyrm_wb_arbiter.sv
// Shares the decode stage's single register-file write port between the execute
// result path and the load-return path, with round-robin arbitration and x0 absorption.
module pyrm_wb_arbiter
    import pyrm_wb_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            reset_pyri,

    input  logic [XLEN-1:0] exec_addr_pyri,
    input  logic [XLEN-1:0] exec_data_pyri,
    input  logic            exec_valid_pyri,
    output logic            exec_retry_pyro,

    input  logic [XLEN-1:0] mem_addr_pyri,
    input  logic [XLEN-1:0] mem_data_pyri,
    input  logic            mem_valid_pyri,
    output logic            mem_retry_pyro,

    output logic [XLEN-1:0] wb_addr_pyro,
    output logic [XLEN-1:0] wb_data_pyro,
    output logic            wb_valid_pyro,
    input  logic            wb_retry_pyri
);

    logic            r_wb_valid;
    logic [XLEN-1:0] r_wb_addr;
    logic [XLEN-1:0] r_wb_data;
    wb_src_e         r_last_src;

    logic w_loadable;
    logic w_exec_x0;
    logic w_mem_x0;
    logic w_exec_req;
    logic w_mem_req;
    logic w_gnt_exec;
    logic w_gnt_mem;

    assign w_loadable = !r_wb_valid || !wb_retry_pyri;
    assign w_exec_x0  = is_x0(exec_addr_pyri[RF_ADDR_BITS-1:0]);
    assign w_mem_x0   = is_x0(mem_addr_pyri[RF_ADDR_BITS-1:0]);

    // Only non-x0 requests compete, and only when the output slot can take a new entry.
    assign w_exec_req = !reset_pyri && w_loadable && exec_valid_pyri && !w_exec_x0;
    assign w_mem_req  = !reset_pyri && w_loadable && mem_valid_pyri  && !w_mem_x0;

    pyrm_wb_rr_pick u_pick (
        .i_req_exec (w_exec_req),
        .i_req_mem  (w_mem_req),
        .i_last_mem (r_last_src == SRC_MEM),
        .o_gnt_exec (w_gnt_exec),
        .o_gnt_mem  (w_gnt_mem)
    );

    assign exec_retry_pyro = reset_pyri || !(w_gnt_exec || (exec_valid_pyri && w_exec_x0));
    assign mem_retry_pyro  = reset_pyri || !(w_gnt_mem  || (mem_valid_pyri  && w_mem_x0));

    always_ff @(posedge clk) begin
        if (reset_pyri) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_last_src <= SRC_MEM;
        end else if (w_loadable) begin
            if (w_gnt_exec) begin
                r_wb_valid <= 1'b1;
                r_wb_addr  <= exec_addr_pyri;
                r_wb_data  <= exec_data_pyri;
                r_last_src <= SRC_EXEC;
            end else if (w_gnt_mem) begin
                r_wb_valid <= 1'b1;
                r_wb_addr  <= mem_addr_pyri;
                r_wb_data  <= mem_data_pyri;
                r_last_src <= SRC_MEM;
            end else begin
                r_wb_valid <= 1'b0;
            end
        end
    end

    assign wb_valid_pyro = r_wb_valid;
    assign wb_addr_pyro  = r_wb_addr;
    assign wb_data_pyro  = r_wb_data;

endmodule

// File: doc/pyrm_wb_arbiter.md
# pyrm_wb_arbiter

Shares the single register-file write port of the decode stage between two writeback producers: the execute result path and the load-return path. Accepts independent valid/retry requests from both, arbitrates round-robin, and drives one registered writeback stream (x-register address plus data) into the decode stage's register-write inputs. Writes to x0 are absorbed here so they never occupy the port.

## Interface
- No parameters. Widths are fixed: 64-bit address word (only [4:0] significant), 64-bit data.
- clk  in  1  clock; all state updates on rising edge
- reset_pyri  in  1  synchronous, active-high reset
- exec_addr_pyri  in  64  execute-result destination register, [4:0] = rd
- exec_data_pyri  in  64  execute-result value
- exec_valid_pyri  in  1  execute request valid
- exec_retry_pyro  out  1  execute request not accepted this cycle
- mem_addr_pyri  in  64  load-return destination register, [4:0] = rd
- mem_data_pyri  in  64  load-return value
- mem_valid_pyri  in  1  load request valid
- mem_retry_pyro  out  1  load request not accepted this cycle
- wb_addr_pyro  out  64  writeback address to decode (registered)
- wb_data_pyro  out  64  writeback data to decode (registered)
- wb_valid_pyro  out  1  writeback valid (registered)
- wb_retry_pyri  in  1  decode not accepting writeback

## Operation
- Handshake on every channel: transfer iff valid && !retry in the same cycle. Producers hold addr/data stable while valid && retry.
- State: one output register (wb_valid, wb_addr, wb_data) and one round-robin bit last_mem (1 = load path granted last).
- Output register is loadable when !wb_valid_pyro, or wb_valid_pyro && !wb_retry_pyri (drained this cycle).
- x0 requests (addr[4:0] == 0): accepted immediately (retry_pyro = 0) whether or not the output register is loadable; never loaded into the output; do not change last_mem; do not take part in arbitration.
- Non-x0 requests compete only if the output register is loadable:
  - exactly one competing: granted.
  - both competing: grant exec if last_mem = 1, else mem.
  - granted requester: retry_pyro = 0; its addr/data loaded into the output register next edge; wb_valid_pyro = 1; last_mem updated (1 if mem, 0 if exec).
- Loadable with no grant: wb_valid_pyro cleared next edge after drain.
- Not loadable: output register holds addr/data/valid unchanged; all non-x0 requesters see retry_pyro = 1.
- retry_pyro = 1 whenever the requester is not granted and not absorbed as x0, including when its valid is low.
- No address-ordering check between paths: the decode scoreboard guarantees at most one outstanding writer per rd.
- wb_addr_pyro is the requester's full 64-bit address word passed unmodified.

## Timing
- Reset (reset_pyri high at edge): wb_valid_pyro = 0, wb_addr_pyro = 0, wb_data_pyro = 0, last_mem = 1 (exec wins first conflict). While reset_pyri is high, exec_retry_pyro = mem_retry_pyro = 1 and no x0 absorption occurs.
- Reset mid-operation: a held writeback is dropped; pending producer requests stay asserted and are arbitrated the first cycle after reset deasserts.
- Latency: accepted at edge N -> wb_valid_pyro/addr/data visible from edge N (registered), consumed by decode in the same cycle if wb_retry_pyri = 0.
- Throughput: one writeback per cycle sustained; back-to-back grants with wb_retry_pyri low.
- retry_pyro outputs are combinational from valids, addr[4:0], wb_valid_pyro, wb_retry_pyri, last_mem and reset_pyri; no combinational path from any *_data_pyri.
- Conflict under continuous contention: strict alternation exec, mem, exec, ...; neither path waits more than one grant.

## Structure
- Opcode/field constants stay in rv64.vh; add `RF_ADDR_BITS (5) there for the rd slice.
- Output register and last_mem built from the existing flop module (reset_pyri on .reset, load unused).
- One sub-module: pyrm_wb_rr_pick, the 2-way round-robin pick (inputs: two requests, last_mem; outputs: two one-hot grants).

## Test plan
- Reset, then exec only: addr=5, data=0x1234 at cycle 1 -> exec_retry_pyro=0 cycle 1; wb_valid=1, wb_addr=5, wb_data=0x1234 from cycle 2.
- Both valid continuously (exec rd=3, mem rd=7), wb_retry_pyri=0 -> grants exec, mem, exec, mem on consecutive cycles; losing side retry=1.
- wb_retry_pyri held 1 for 3 cycles with output valid -> wb_addr/data unchanged, both non-x0 retries=1; first cycle retry drops -> next pending request granted same cycle.
- mem addr=0 data=0xFFFF while output stalled -> mem_retry_pyro=0 that cycle, wb outputs unchanged, last_mem unchanged.
- reset_pyri pulsed while wb_valid=1 and both requests pending -> after edge wb_valid=0, addr/data=0; first post-reset conflict granted to exec.
